harmonic_scheduler: RTL and testbench

Sequences the shared multiply-accumulate adder across all harmonics of one output sample in the additive oscillator. On each sample-rate strobe it clears the accumulator, then for each harmonic fetches a sine sample from the wavetable lookup, issues one scaled-add with a per-harmonic level, and waits for completion. It then saturates the final sum into a 16-bit output sample. It sits between the sample-rate timer, the wavetable lookup and the adder, and owns the adder for the whole frame.

---
 rtl/harmonic_scheduler_pkg.sv | 28 ++
 rtl/harmonic_scheduler.sv | 132 +++++++++++++
 tb/tb_harmonic_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/harmonic_scheduler_pkg.sv
// Shared definitions for the additive-oscillator harmonic scheduler
// and the scaled-add adder bench.
package harmonic_scheduler_pkg;

    localparam int HS_DIVISOR_BITS = 11;
    localparam int LEVEL_MAX = (2 ** (HS_DIVISOR_BITS - 1)) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOOKUP,
        S_MAC_START,
        S_MAC_WAIT,
        S_OUTPUT
    } hs_state_t;

    function automatic logic signed [15:0] sat16(
        input logic signed [31:0] v
    );
        if (v > 32'sd32767)
            return 16'sh7fff;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/harmonic_scheduler.sv
// Walks every harmonic of one output sample through the shared
// scaled-add unit, then saturates the accumulated sum to 16 bits.
module harmonic_scheduler
    import harmonic_scheduler_pkg::*;
#(
    parameter int DIVISOR_BITS  = 11,
    parameter int MAX_HARMONICS = 64,
    parameter int HARM_BITS     = 6,
    parameter int OUTPUT_SHIFT  = 2
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    input  logic                           i_Frame_Start,
    input  logic [HARM_BITS:0]             i_Harmonic_Count,
    input  logic [2:0]                     i_Decay_Shift,
    output logic                           o_Lookup_Req,
    output logic [HARM_BITS-1:0]           o_Harmonic,
    input  logic                           i_Lookup_Valid,
    input  logic signed [15:0]             i_Lookup_Sample,
    output logic                           o_Adder_Clear,
    output logic                           o_Adder_Start,
    output logic signed [DIVISOR_BITS-1:0] o_Adder_Multiple,
    output logic signed [15:0]             o_Adder_Sample,
    input  logic                           i_Adder_Done,
    input  logic signed [31:0]             i_Accumulator,
    output logic signed [15:0]             o_Sample,
    output logic                           o_Sample_Valid,
    output logic                           o_Overrun,
    output logic                           o_Busy
);

    localparam int LW = DIVISOR_BITS - 1;
    localparam logic [LW-1:0] LEVEL_INIT = LW'(LEVEL_MAX);
    localparam logic [HARM_BITS:0] ONE = {{HARM_BITS{1'b0}}, 1'b1};

    hs_state_t state;
    logic [HARM_BITS:0]   count_q;
    logic [2:0]           decay_q;
    logic [HARM_BITS-1:0] index;
    logic [LW-1:0]        level;
    logic                 first_wait;
    logic                 last_harm;
    logic signed [31:0]   shifted;

    assign last_harm = ({1'b0, index} == (count_q - ONE));
    assign shifted   = i_Accumulator >>> OUTPUT_SHIFT;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state            <= S_IDLE;
            count_q          <= '0;
            decay_q          <= '0;
            index            <= '0;
            level            <= '0;
            first_wait       <= 1'b0;
            o_Lookup_Req     <= 1'b0;
            o_Harmonic       <= '0;
            o_Adder_Clear    <= 1'b0;
            o_Adder_Start    <= 1'b0;
            o_Adder_Multiple <= '0;
            o_Adder_Sample   <= '0;
            o_Sample         <= '0;
            o_Sample_Valid   <= 1'b0;
            o_Overrun        <= 1'b0;
            o_Busy           <= 1'b0;
        end else begin
            o_Adder_Clear  <= 1'b0;
            o_Adder_Start  <= 1'b0;
            o_Sample_Valid <= 1'b0;
            o_Overrun      <= i_Frame_Start && (state != S_IDLE);
            unique case (state)
                S_IDLE: begin
                    if (i_Frame_Start) begin
                        count_q       <= i_Harmonic_Count;
                        decay_q       <= i_Decay_Shift;
                        index         <= '0;
                        level         <= LEVEL_INIT;
                        o_Adder_Clear <= 1'b1;
                        o_Busy        <= 1'b1;
                        state         <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (count_q == '0) begin
                        state <= S_OUTPUT;
                    end else begin
                        o_Lookup_Req <= 1'b1;
                        o_Harmonic   <= index;
                        state        <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (i_Lookup_Valid) begin
                        o_Lookup_Req     <= 1'b0;
                        o_Adder_Sample   <= i_Lookup_Sample;
                        o_Adder_Multiple <= {1'b0, level};
                        o_Adder_Start    <= 1'b1;
                        state            <= S_MAC_START;
                    end
                end
                S_MAC_START: begin
                    first_wait <= 1'b1;
                    state      <= S_MAC_WAIT;
                end
                S_MAC_WAIT: begin
                    first_wait <= 1'b0;
                    // done is still high from the previous add on cycle one
                    if (!first_wait && i_Adder_Done) begin
                        if (decay_q != 3'd0)
                            level <= level - (level >> decay_q);
                        index <= index + 1'b1;
                        if (last_harm) begin
                            state <= S_OUTPUT;
                        end else begin
                            o_Lookup_Req <= 1'b1;
                            o_Harmonic   <= index + 1'b1;
                            state        <= S_LOOKUP;
                        end
                    end
                end
                S_OUTPUT: begin
                    o_Sample       <= sat16(shifted);
                    o_Sample_Valid <= 1'b1;
                    o_Busy         <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Directed bench for harmonic_scheduler with behavioural wavetable
// and scaled-add adder models.
module tb_harmonic_scheduler;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               strobe = 1'b0;
    logic [6:0]         hcount = '0;
    logic [2:0]         decay = '0;
    logic               req;
    logic [5:0]         harm;
    logic               lv = 1'b0;
    logic signed [15:0] ls = '0;
    logic               aclr;
    logic               astart;
    logic signed [10:0] amult;
    logic signed [15:0] asamp;
    logic               adone = 1'b1;
    logic signed [31:0] acc = '0;
    logic signed [15:0] osamp;
    logic               ovalid;
    logic               overrun;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int valid_cnt = 0, valid_cyc = -1;
    int ov_cnt = 0, ov_cyc = -1;
    int clr_cyc = -1;
    int lk_delay = 0;
    int wait_cnt = 0;
    int hold_err = 0;
    logic [5:0] held = '0;
    logic signed [15:0] lk_value = '0;
    logic pend = 1'b0;
    int mults[$];
    int samps[$];
    int harms[$];

    harmonic_scheduler dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Frame_Start(strobe),
        .i_Harmonic_Count(hcount),
        .i_Decay_Shift(decay),
        .o_Lookup_Req(req),
        .o_Harmonic(harm),
        .i_Lookup_Valid(lv),
        .i_Lookup_Sample(ls),
        .o_Adder_Clear(aclr),
        .o_Adder_Start(astart),
        .o_Adder_Multiple(amult),
        .o_Adder_Sample(asamp),
        .i_Adder_Done(adone),
        .i_Accumulator(acc),
        .o_Sample(osamp),
        .o_Sample_Valid(ovalid),
        .o_Overrun(overrun),
        .o_Busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req && lv)
            harms.push_back(int'(harm));
    end

    // adder: done drops the cycle after start, sum lands one cycle later
    always @(posedge clk) begin
        logic signed [31:0] p;
        p = asamp * amult;
        if (rst) begin
            adone <= 1'b1;
            pend  <= 1'b0;
        end else if (aclr) begin
            acc <= '0;
        end
        if (!rst && astart) begin
            mults.push_back(int'(amult));
            samps.push_back(int'(asamp));
            adone <= 1'b0;
            pend  <= 1'b1;
        end else if (!rst && pend) begin
            acc   <= acc + (p >>> 11);
            adone <= 1'b1;
            pend  <= 1'b0;
        end
    end

    // wavetable: answers after lk_delay wait cycles
    always @(negedge clk) begin
        if (req) begin
            if (wait_cnt == 0)
                held = harm;
            if (harm !== held)
                hold_err++;
            if (wait_cnt >= lk_delay) begin
                lv = 1'b1;
                ls = lk_value;
            end else begin
                lv = 1'b0;
                wait_cnt++;
            end
        end else begin
            lv = 1'b0;
            wait_cnt = 0;
        end
        if (ovalid) begin
            valid_cnt++;
            valid_cyc = cyc - t0;
        end
        if (overrun) begin
            ov_cnt++;
            ov_cyc = cyc - t0;
        end
        if (aclr)
            clr_cyc = cyc - t0;
    end

    task automatic start_frame(input int n, input int d,
                               input int v, input int dly);
        mults.delete();
        samps.delete();
        harms.delete();
        hold_err = 0;
        lk_value = 16'(v);
        lk_delay = dly;
        @(negedge clk);
        hcount = 7'(n);
        decay  = 3'(d);
        strobe = 1'b1;
        t0 = cyc;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic wait_valid(input int start_cnt, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (valid_cnt != start_cnt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req, aclr, astart, ovalid, overrun, busy} !== 6'b0) begin
            $display("FAIL reset_ctrl got %b want 000000",
                     {req, aclr, astart, ovalid, overrun, busy});
            n_err++;
        end
        n_vec++;
        if (osamp !== 16'sd0 || amult !== 11'sd0 || harm !== 6'd0) begin
            $display("FAIL reset_data sample %0d mult %0d harm %0d want 0",
                     osamp, amult, harm);
            n_err++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        bit ok;
        start_frame(1, 0, 16384, 0);
        wait_valid(valid_cnt, ok);
        n_vec++;
        if (!ok || valid_cyc != 7) begin
            $display("FAIL single_latency got %0d want 7", valid_cyc);
            n_err++;
        end
        n_vec++;
        if (mults.size() != 1 || mults[0] != 1023 || samps[0] != 16384) begin
            $display("FAIL single_operands got n=%0d want mult 1023 samp 16384",
                     mults.size());
            n_err++;
        end
        n_vec++;
        if (acc !== 32'sd8184 || osamp !== 16'sd2046) begin
            $display("FAIL single_sample got acc %0d out %0d want 8184 2046",
                     acc, osamp);
            n_err++;
        end
    endtask

    task automatic test_decay;
        bit ok;
        start_frame(3, 1, 1000, 0);
        wait_valid(valid_cnt, ok);
        n_vec++;
        if (!ok || valid_cyc != 15) begin
            $display("FAIL decay_latency got %0d want 15", valid_cyc);
            n_err++;
        end
        n_vec++;
        if (mults.size() != 3 || mults[0] != 1023 || mults[1] != 512
            || mults[2] != 256) begin
            $display("FAIL decay_levels got n=%0d want 1023,512,256",
                     mults.size());
            n_err++;
        end
        n_vec++;
        if (osamp !== 16'sd218) begin
            $display("FAIL decay_sample got %0d want 218", osamp);
            n_err++;
        end
        n_vec++;
        if (harms.size() != 3 || harms[0] != 0 || harms[1] != 1
            || harms[2] != 2) begin
            $display("FAIL decay_harmonics got n=%0d want 0,1,2",
                     harms.size());
            n_err++;
        end
    endtask

    task automatic test_saturate;
        bit ok;
        start_frame(64, 0, -32768, 0);
        wait_valid(valid_cnt, ok);
        n_vec++;
        if (!ok || valid_cyc != 259) begin
            $display("FAIL sat_latency got %0d want 259", valid_cyc);
            n_err++;
        end
        n_vec++;
        if (acc !== -32'sd1047552 || osamp !== -16'sd32768) begin
            $display("FAIL sat_sample got acc %0d out %0d want -1047552 -32768",
                     acc, osamp);
            n_err++;
        end
        n_vec++;
        if (harms.size() != 64 || harms[63] != 63) begin
            $display("FAIL sat_count got %0d lookups want 64", harms.size());
            n_err++;
        end
    endtask

    task automatic test_wait;
        bit ok;
        start_frame(2, 0, 100, 3);
        wait_valid(valid_cnt, ok);
        n_vec++;
        if (!ok || valid_cyc != 17) begin
            $display("FAIL wait_latency got %0d want 17", valid_cyc);
            n_err++;
        end
        n_vec++;
        if (hold_err != 0 || harms.size() != 2 || harms[1] != 1) begin
            $display("FAIL wait_stable got %0d glitches want 0", hold_err);
            n_err++;
        end
        lk_delay = 0;
    endtask

    task automatic test_overrun;
        bit ok;
        int vc;
        int oc;
        oc = ov_cnt;
        start_frame(3, 0, 200, 0);
        repeat (4) @(negedge clk);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        vc = valid_cnt;
        wait_valid(vc, ok);
        n_vec++;
        if (ov_cnt != oc + 1 || ov_cyc != 6) begin
            $display("FAIL overrun_pulse got cnt %0d cyc %0d want 1 at 6",
                     ov_cnt - oc, ov_cyc);
            n_err++;
        end
        n_vec++;
        if (!ok || valid_cyc != 15 || mults.size() != 3) begin
            $display("FAIL overrun_frame got cyc %0d adds %0d want 15 3",
                     valid_cyc, mults.size());
            n_err++;
        end
        repeat (30) @(negedge clk);
        n_vec++;
        if (valid_cnt != vc + 1 || busy !== 1'b0) begin
            $display("FAIL overrun_no_second got %0d frames busy %b want 1 0",
                     valid_cnt - vc, busy);
            n_err++;
        end
    endtask

    task automatic test_zero;
        bit ok;
        start_frame(0, 0, 500, 0);
        wait_valid(valid_cnt, ok);
        n_vec++;
        if (clr_cyc != 1) begin
            $display("FAIL zero_clear got %0d want 1", clr_cyc);
            n_err++;
        end
        n_vec++;
        if (!ok || valid_cyc != 3 || osamp !== 16'sd0 || mults.size() != 0) begin
            $display("FAIL zero_frame got cyc %0d out %0d want 3 0",
                     valid_cyc, osamp);
            n_err++;
        end
    endtask

    task automatic test_mid_reset;
        int vc;
        start_frame(3, 0, 300, 0);
        vc = valid_cnt;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({req, aclr, astart, ovalid, overrun, busy} !== 6'b0
            || amult !== 11'sd0 || asamp !== 16'sd0 || osamp !== 16'sd0) begin
            $display("FAIL midreset_outputs got %b mult %0d samp %0d want 0",
                     {req, aclr, astart, ovalid, overrun, busy}, amult, asamp);
            n_err++;
        end
        repeat (25) @(negedge clk);
        n_vec++;
        if (valid_cnt != vc || busy !== 1'b0) begin
            $display("FAIL midreset_idle got %0d pulses busy %b want 0 0",
                     valid_cnt - vc, busy);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_decay();
        test_saturate();
        test_wait();
        test_overrun();
        test_zero();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
